// File: rtl/sram_controller.sv
// Word load/store to two 16-bit accesses on an asynchronous SRAM; ready low freezes the pipeline.
// Optional SRAM_PERF_CNT_EN adds rd_count/wr_count completion counters.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned SRAM_AW       = 18,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_en,
    input  logic               write_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
`ifdef SRAM_PERF_CNT_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        off;
    logic               unused_off;
    logic               req;
    logic               phase_hi;

    assign off        = address - BASE_ADDR;
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
    assign req        = read_en | write_en;
    assign phase_hi   = (state_q == StHigh);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready       = 1'b1;
        sram_addr   = '0;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        case (state_q)
            StIdle: begin
                if (req) begin
                    ready   = 1'b0;
                    // read wins when both requests are present
                    op_wr_d = ~read_en;
                    word_d  = off[SRAM_AW:2];
                    wdata_d = wdata;
                    cnt_d   = CntLoad;
                    state_d = StLow;
                end
            end
            StLow, StHigh: begin
                ready     = 1'b0;
                sram_addr = {word_q, phase_hi};
                if (op_wr_q) begin
                    sram_dq_out = phase_hi ? wdata_q[31:16] : wdata_q[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end else begin
                    sram_oe_n = 1'b0;
                    if (cnt_q == 4'd0) begin
                        if (phase_hi) rdata_d[31:16] = sram_dq_in;
                        else          rdata_d[15:0]  = sram_dq_in;
                    end
                end
                if (cnt_q == 4'd0) begin
                    cnt_d   = CntLoad;
                    state_d = phase_hi ? StDone : StHigh;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

`ifdef SRAM_PERF_CNT_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == StDone) begin
            if (op_wr_q) wr_count_d = wr_count_q + 32'd1;
            else         rd_count_d = rd_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 32'h0;
            wr_count_q <= 32'h0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    // counters absent in the default build
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: driver pushes expected transactions, bus monitor checks them.
// Build with SRAM_PERF_CNT_EN defined to also check the completion counters.
module tb_sram_controller;

    localparam int unsigned AC   = 2;
    localparam int unsigned BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en, write_en;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_PERF_CNT_EN
    logic [31:0] rd_count, wr_count;
`endif

    sram_controller #(
        .BASE_ADDR    (32'd1024),
        .SRAM_AW      (18),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read_en    (read_en),
        .write_en   (write_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce_n  (sram_ce_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
`ifdef SRAM_PERF_CNT_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    // External asynchronous SRAM: 256K half-words
    logic [15:0] sram_mem [0:262143];
    assign sram_dq_in = sram_oe_n ? 16'h5A5A : sram_mem[sram_addr];
    always @(negedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

    typedef struct {
        bit          wr;
        logic [16:0] word;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
        logic        we_n;
        logic        oe_n;
        logic        dq_oe;
    } bus_t;

    txn_t        exp_q[$];
    bus_t        bus_q[$];
    logic [31:0] ref_mem [int unsigned];
    int          tests = 0;
    int          fails = 0;
    int          low_cnt = 0;
    logic [31:0] last_rdata = 32'h0;
    int          n_rd = 0;
    int          n_wr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Word index seen by the SRAM: byte offset from BASE, divided by 4, modulo 2^17 words
    function automatic logic [16:0] word_of(input logic [31:0] a);
        int unsigned off;
        off = a - BASE;
        return 17'((off / 4) % (1 << 17));
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
        return 32'h0;
    endfunction

    // Monitor: collects bus activity while ready is low, scores it when ready returns
    always @(negedge clk) begin
        if (rst) begin
            low_cnt    = 0;
            last_rdata = 32'h0;
            n_rd       = 0;
            n_wr       = 0;
            bus_q.delete();
        end else begin
            check("tied_ce_ub_lb", {29'h0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h0);
            if (!sram_dq_oe) check("we_n_high_without_oe", {31'h0, sram_we_n}, 32'h1);
            if (!ready) begin
                low_cnt++;
                if (!sram_we_n || !sram_oe_n)
                    bus_q.push_back('{sram_addr, sram_dq_out, sram_we_n, sram_oe_n, sram_dq_oe});
            end else begin
                check("bus_idle_when_ready", {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h6);
                if (low_cnt > 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_access", 32'h1, 32'h0);
                    end else begin
                        txn_t t;
                        t = exp_q.pop_front();
                        check("latency_ready_low", low_cnt, 2 * AC + 1);
                        check("bus_cycle_count", bus_q.size(), 2 * AC);
                        foreach (bus_q[i]) begin
                            logic        hi;
                            logic [15:0] half;
                            hi = (i >= AC);
                            half = hi ? t.data[31:16] : t.data[15:0];
                            check("sram_addr", {14'h0, bus_q[i].a}, {14'h0, t.word, hi});
                            if (t.wr) begin
                                check("wr_strobes", {29'h0, bus_q[i].we_n, bus_q[i].oe_n,
                                      bus_q[i].dq_oe}, 32'h3);
                                check("wr_dq_out", {16'h0, bus_q[i].d}, {16'h0, half});
                            end else begin
                                check("rd_strobes", {29'h0, bus_q[i].we_n, bus_q[i].oe_n,
                                      bus_q[i].dq_oe}, 32'h4);
                            end
                        end
                        if (t.wr) n_wr++;
                        else begin
                            n_rd++;
                            last_rdata = t.data;
                        end
                    end
                    low_cnt = 0;
                    bus_q.delete();
                end
                check("rdata", rdata, last_rdata);
            end
        end
    end

    task automatic idle(input int n);
        @(posedge clk); #1;
        read_en  = 1'b0;
        write_en = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        txn_t t;
        int   waited;
        @(posedge clk); #1;
        read_en  = rd;
        write_en = wr;
        address  = a;
        wdata    = d;
        t.wr   = !rd;
        t.word = word_of(a);
        if (rd) t.data = ref_read(t.word);
        else begin
            t.data = d;
            ref_mem[int'(t.word)] = d;
        end
        exp_q.push_back(t);
        @(negedge clk);
        if (!hold) begin
            @(posedge clk); #1;
            read_en  = 1'b0;
            write_en = 1'b0;
            wdata    = $urandom;
            address  = $urandom;
        end
        waited = 0;
        while (1) begin
            @(negedge clk);
            waited++;
            if (ready) break;
            if (waited > 40) begin
                check("ready_timeout", 32'h0, 32'h1);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        rst = 1'b1; read_en = 1'b0; write_en = 1'b0; address = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_ready", {31'h0, ready}, 32'h1);
        check("reset_rdata", rdata, 32'h0);
        check("reset_strobes", {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'h6);

        issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b1);
        issue(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'd1024 + 32'h7FFFC, 32'h13572468, 1'b1);
        issue(1'b1, 1'b0, 32'd1024 + 32'h7FFFC, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'd1026, 32'h0, 1'b1);
        issue(1'b1, 1'b1, 32'd1024, 32'hFFFF0000, 1'b1);
        issue(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'd1024 + 32'h80000, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 32'd1040, 32'hA1B2C3D4, 1'b1);
        issue(1'b0, 1'b1, 32'd1044, 32'h55AA33CC, 1'b1);
        issue(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'd1044, 32'h0, 1'b0);
        idle(3);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            bit          rd, wr;
            a = BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a + ($urandom_range(1, 7) << 19);
            rd = $urandom_range(0, 1);
            wr = !rd || ($urandom_range(0, 3) == 0);
            issue(rd, wr, a, $urandom, $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

`ifdef SRAM_PERF_CNT_EN
        @(negedge clk);
        check("rd_count", rd_count, n_rd);
        check("wr_count", wr_count, n_wr);
`endif

        // Reset during the high phase of a write to a word that is never read back
        @(posedge clk); #1;
        write_en = 1'b1; address = BASE + 32'd4000; wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; write_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'h0, ready}, 32'h1);
        check("rst_mid_we_n", {31'h0, sram_we_n}, 32'h1);
        check("rst_mid_rdata", rdata, 32'h0);
`ifdef SRAM_PERF_CNT_EN
        check("rst_rd_count", rd_count, 32'h0);
        check("rst_wr_count", wr_count, 32'h0);
`endif
        issue(1'b1, 1'b0, 32'd1024 + 32'h7FFFC, 32'h0, 1'b1);
        idle(3);
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
